// File: rtl/tisc_spi_engine.sv
// rtl/tisc_spi_engine.sv - WISHBONE SPI master (mode 0, MSB first) with TX/RX byte FIFOs for the TISC config flash
// Optional CTRL[2] MOSI->sample loopback is built when TISC_SPI_LOOPBACK_EN is defined.
module tisc_spi_engine #(
   parameter int         FIFO_AW      = 2,
   parameter logic [7:0] CLKDIV_RESET = 8'd3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [5:0]  adr_i,
   input  logic [31:0] dat_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        rty_o,
   output logic        irq_o,
   output logic        CS_B,
   output logic        SCK,
   output logic        MOSI,
   input  logic        MISO
);

   localparam int                 DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;
   localparam logic [FIFO_AW:0]   CNT_ONE  = 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [7:0]         shift_q, shift_d, div_q, div_d, reload_q, reload_d, clkdiv_q, clkdiv_d;
   logic [2:0]         bitcnt_q, bitcnt_d;
   logic               sck_q, sck_d, mosi_q, mosi_d, samp_q, samp_d;
   logic               cs_q, cs_d, irq_en_q, irq_en_d, irq_q, irq_d;
   logic               rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
   logic [7:0]         tx_mem_q [DEPTH];
   logic [7:0]         tx_mem_d [DEPTH];
   logic [7:0]         rx_mem_q [DEPTH];
   logic [7:0]         rx_mem_d [DEPTH];
   logic [FIFO_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [FIFO_AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

   logic bus_wr, bus_rd, tx_empty, tx_full, rx_empty, rx_full, busy;
   logic tx_push, tx_push_ok, tx_pop, rx_push, rx_push_ok, rx_pop, tx_avail;
   logic sample_in, loop_bit, first_high;
   logic unused_ok;

   assign ack_o = cyc_i & stb_i;
   assign err_o = 1'b0;
   assign rty_o = 1'b0;
   assign irq_o = irq_q;
   assign CS_B  = ~cs_q;
   assign SCK   = sck_q;
   assign MOSI  = mosi_q;
   assign unused_ok = ^{sel_i, adr_i[5:4], adr_i[1:0], dat_i[31:15], dat_i[12:8]};

   assign bus_wr   = ack_o & we_i;
   assign bus_rd   = ack_o & ~we_i;
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == FULL_CNT);
   assign busy     = (state_q != S_IDLE) || !tx_empty;

   assign tx_push    = bus_wr && (adr_i[3:2] == 2'd2);
   assign rx_pop     = bus_rd && (adr_i[3:2] == 2'd3) && !rx_empty;
   assign tx_pop     = (state_q == S_LOAD);
   assign rx_push    = (state_q == S_DONE);
   // A pop in the same cycle frees the slot, so a push into a full FIFO is not an overflow.
   assign tx_push_ok = tx_push && (!tx_full || tx_pop);
   assign rx_push_ok = rx_push && (!rx_full || rx_pop);
   assign tx_avail   = !tx_empty || tx_push_ok;
   assign first_high = (div_q == reload_q);

   logic loop_q, loop_d;
`ifdef TISC_SPI_LOOPBACK_EN
   assign sample_in = loop_q ? mosi_q : MISO;
   assign loop_bit  = loop_q;
`else
   assign sample_in = MISO;
   assign loop_bit  = 1'b0;
`endif

   always_comb begin
      tx_mem_d = tx_mem_q;
      tx_wp_d  = tx_wp_q;
      tx_rp_d  = tx_rp_q;
      tx_cnt_d = tx_cnt_q;
      rx_mem_d = rx_mem_q;
      rx_wp_d  = rx_wp_q;
      rx_rp_d  = rx_rp_q;
      rx_cnt_d = rx_cnt_q;
      if (tx_push_ok) begin
         tx_mem_d[tx_wp_q] = dat_i[7:0];
         tx_wp_d           = tx_wp_q + PTR_ONE;
      end
      if (tx_pop) tx_rp_d = tx_rp_q + PTR_ONE;
      if (tx_push_ok && !tx_pop) tx_cnt_d = tx_cnt_q + CNT_ONE;
      else if (!tx_push_ok && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;
      if (rx_push_ok) begin
         rx_mem_d[rx_wp_q] = shift_q;
         rx_wp_d           = rx_wp_q + PTR_ONE;
      end
      if (rx_pop) rx_rp_d = rx_rp_q + PTR_ONE;
      if (rx_push_ok && !rx_pop) rx_cnt_d = rx_cnt_q + CNT_ONE;
      else if (!rx_push_ok && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;
   end

   always_comb begin
      cs_d     = cs_q;
      irq_en_d = irq_en_q;
      loop_d   = loop_q;
      clkdiv_d = clkdiv_q;
      rx_ovf_d = rx_ovf_q;
      tx_ovf_d = tx_ovf_q;
      if (bus_wr && (adr_i[3:2] == 2'd0)) begin
         cs_d     = dat_i[0];
         irq_en_d = dat_i[1];
`ifdef TISC_SPI_LOOPBACK_EN
         loop_d   = dat_i[2];
`endif
         if (dat_i[13]) rx_ovf_d = 1'b0;
         if (dat_i[14]) tx_ovf_d = 1'b0;
      end
      if (bus_wr && (adr_i[3:2] == 2'd1)) clkdiv_d = dat_i[7:0];
      if (tx_push && !tx_push_ok) tx_ovf_d = 1'b1;
      if (rx_push && !rx_push_ok) rx_ovf_d = 1'b1;
      irq_d = irq_en_q & ~busy & ~rx_empty;
   end

   always_comb begin
      dat_o = '0;
      case (adr_i[3:2])
         2'd0: dat_o = {17'b0, tx_ovf_q, rx_ovf_q, rx_empty, rx_full, tx_empty, tx_full, busy,
                        5'b0, loop_bit, irq_en_q, cs_q};
         2'd1: dat_o = {24'b0, clkdiv_q};
         2'd3: if (!rx_empty) dat_o = {1'b1, 23'b0, rx_mem_q[rx_rp_q]};
         default: dat_o = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      div_d    = div_q;
      reload_d = reload_q;
      mosi_d   = mosi_q;
      samp_d   = samp_q;
      case (state_q)
         S_IDLE: if (tx_avail && !rx_full) state_d = S_LOAD;
         S_LOAD: begin
            shift_d  = tx_mem_q[tx_rp_q];
            mosi_d   = tx_mem_q[tx_rp_q][7];
            reload_d = clkdiv_q;
            div_d    = clkdiv_q;
            bitcnt_d = 3'd0;
            state_d  = S_LOW;
         end
         S_LOW: begin
            if (div_q == 8'd0) begin
               div_d   = reload_q;
               state_d = S_HIGH;
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_HIGH: begin
            // MISO is captured on the rising-edge cycle and held until the phase ends.
            if (first_high) samp_d = sample_in;
            if (div_q == 8'd0) begin
               shift_d = {shift_q[6:0], first_high ? sample_in : samp_q};
               div_d   = reload_q;
               if (bitcnt_q == 3'd7) begin
                  state_d = S_DONE;
               end else begin
                  mosi_d   = shift_q[6];
                  bitcnt_d = bitcnt_q + 3'd1;
                  state_d  = S_LOW;
               end
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_DONE: state_d = (tx_avail && (rx_cnt_d != FULL_CNT)) ? S_LOAD : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      sck_d = (state_d == S_HIGH);
   end

   always_ff @(posedge clk_i) begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         bitcnt_q <= '0;
         div_q    <= '0;
         reload_q <= '0;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         samp_q   <= 1'b0;
         cs_q     <= 1'b0;
         irq_en_q <= 1'b0;
         loop_q   <= 1'b0;
         irq_q    <= 1'b0;
         clkdiv_q <= CLKDIV_RESET;
         rx_ovf_q <= 1'b0;
         tx_ovf_q <= 1'b0;
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         div_q    <= div_d;
         reload_q <= reload_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
         samp_q   <= samp_d;
         cs_q     <= cs_d;
         irq_en_q <= irq_en_d;
         loop_q   <= loop_d;
         irq_q    <= irq_d;
         clkdiv_q <= clkdiv_d;
         rx_ovf_q <= rx_ovf_d;
         tx_ovf_q <= tx_ovf_d;
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end

endmodule
